// File: rtl/bp_nonsynth_cosim_commit_arbiter_if.sv
// Bundles the per-core commit streams, the shared checker channel and the status outputs.
// The slave modport is the arbiter; the master modport is the commit sources plus the checker.
interface bp_nonsynth_cosim_commit_arbiter_if #(
    parameter int num_core_p      = 4,
    parameter int payload_width_p = 160,
    parameter int cnt_width_p     = 32
);
    localparam int id_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    logic [cnt_width_p-1:0]                instr_cap_i;
    logic [num_core_p-1:0]                 commit_v_i;
    logic [num_core_p-1:0]                 commit_instret_i;
    logic [num_core_p-1:0]                 commit_trap_i;
    logic [num_core_p*payload_width_p-1:0] commit_payload_i;
    logic [num_core_p-1:0]                 commit_ready_o;
    logic                                  chk_v_o;
    logic [id_w-1:0]                       chk_core_id_o;
    logic                                  chk_instret_o;
    logic                                  chk_trap_o;
    logic [payload_width_p-1:0]            chk_payload_o;
    logic                                  chk_yumi_i;
    logic [num_core_p-1:0]                 core_finish_o;
    logic                                  done_o;
    logic [num_core_p*cnt_width_p-1:0]     instr_cnt_o;

    modport slave (
        input  instr_cap_i, commit_v_i, commit_instret_i, commit_trap_i, commit_payload_i, chk_yumi_i,
        output commit_ready_o, chk_v_o, chk_core_id_o, chk_instret_o, chk_trap_o, chk_payload_o,
        output core_finish_o, done_o, instr_cnt_o
    );

    modport master (
        output instr_cap_i, commit_v_i, commit_instret_i, commit_trap_i, commit_payload_i, chk_yumi_i,
        input  commit_ready_o, chk_v_o, chk_core_id_o, chk_instret_o, chk_trap_o, chk_payload_o,
        input  core_finish_o, done_o, instr_cnt_o
    );
endinterface

// File: rtl/bp_nonsynth_cosim_commit_arbiter.sv
// Round-robin share of one cosim checker channel between per-core commit streams, with retire caps.
// Latency: grant cycle N -> chk_v_o at N+1; all cores stall while the output register is full and not yumied.
module bp_nonsynth_cosim_commit_arbiter #(
    parameter int num_core_p      = 4,
    parameter int payload_width_p = 160,
    parameter int cnt_width_p     = 32
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bp_nonsynth_cosim_commit_arbiter_if.slave bus
);
    localparam int id_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    typedef enum logic [1:0] {e_run, e_drain, e_done} state_e;

    state_e                      r_state, w_state_nxt;
    logic [id_w-1:0]             r_ptr, w_gnt_id;
    logic                        w_gnt_found, w_gnt, w_load_ok, w_run;
    logic [num_core_p-1:0]       w_elig, r_finish;
    logic [cnt_width_p-1:0]      r_cnt [num_core_p];
    logic                        r_chk_v, r_instret, r_trap;
    logic [id_w-1:0]             r_core_id;
    logic [payload_width_p-1:0]  r_payload;

    // Reset gates the grant combinationally so no ready escapes while reset is held.
    assign w_run     = reset_n_i && (r_state == e_run);
    assign w_load_ok = !r_chk_v || bus.chk_yumi_i;
    assign w_elig    = bus.commit_v_i & ~r_finish & {num_core_p{w_run}};
    assign w_gnt     = w_gnt_found && w_load_ok;

    // First eligible core scanning upward from the pointer, wrapping at num_core_p.
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < num_core_p; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= num_core_p) idx = idx - num_core_p;
            if (!w_gnt_found && w_elig[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = id_w'(idx);
            end
        end
    end

    always_comb begin
        bus.commit_ready_o = '0;
        if (w_gnt) bus.commit_ready_o[w_gnt_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr     <= '0;
            r_chk_v   <= 1'b0;
            r_core_id <= '0;
            r_instret <= 1'b0;
            r_trap    <= 1'b0;
            r_payload <= '0;
        end else if (w_gnt) begin
            r_ptr     <= (w_gnt_id == id_w'(num_core_p - 1)) ? '0 : w_gnt_id + 1'b1;
            r_chk_v   <= 1'b1;
            r_core_id <= w_gnt_id;
            r_instret <= bus.commit_instret_i[w_gnt_id];
            r_trap    <= bus.commit_trap_i[w_gnt_id];
            r_payload <= bus.commit_payload_i[w_gnt_id*payload_width_p +: payload_width_p];
        end else if (bus.chk_yumi_i) begin
            r_chk_v   <= 1'b0;
        end
    end

    // Counters saturate; finish compares against the live cap so a cap change applies immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_finish <= '0;
            for (int i = 0; i < num_core_p; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < num_core_p; i++) begin
                if (w_gnt && (w_gnt_id == id_w'(i)) && bus.commit_instret_i[i]
                    && !bus.commit_trap_i[i] && (r_cnt[i] != '1))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                if ((bus.instr_cap_i != '0) && (r_cnt[i] == bus.instr_cap_i))
                    r_finish[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= e_run;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_run:   if (&r_finish) w_state_nxt = e_drain;
            e_drain: if (!r_chk_v || bus.chk_yumi_i) w_state_nxt = e_done;
            e_done:  w_state_nxt = e_done;
            default: w_state_nxt = e_run;
        endcase
    end

    assign bus.chk_v_o       = r_chk_v;
    assign bus.chk_core_id_o = r_core_id;
    assign bus.chk_instret_o = r_instret;
    assign bus.chk_trap_o    = r_trap;
    assign bus.chk_payload_o = r_payload;
    assign bus.core_finish_o = r_finish;
    assign bus.done_o        = (r_state == e_done);

    always_comb begin
        bus.instr_cnt_o = '0;
        for (int i = 0; i < num_core_p; i++) bus.instr_cnt_o[i*cnt_width_p +: cnt_width_p] = r_cnt[i];
    end

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.chk_yumi_i |-> r_chk_v);
endmodule

// File: tb/tb_bp_nonsynth_cosim_commit_arbiter.sv
// Directed bench: arbitration vector table plus sequences for backpressure, traps, caps/done and async reset.
module tb_bp_nonsynth_cosim_commit_arbiter;
    localparam int N  = 4;
    localparam int PW = 160;
    localparam int CW = 32;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_nonsynth_cosim_commit_arbiter_if #(.num_core_p(N), .payload_width_p(PW), .cnt_width_p(CW)) bus();

    bp_nonsynth_cosim_commit_arbiter #(.num_core_p(N), .payload_width_p(PW), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int seq[N], lim[N], trap_cnt[N], exp_seq[N], mdl_cnt[N];
    int n_acc, n_cons;
    logic [N-1:0] en = '0;
    logic yumi_en = 1'b0;

    // Each core emits records numbered by seq; the first trap_cnt records of a core are traps.
    assign bus.chk_yumi_i = yumi_en & bus.chk_v_o;
    always_comb begin
        bus.commit_v_i       = '0;
        bus.commit_trap_i    = '0;
        bus.commit_instret_i = '0;
        bus.commit_payload_i = '0;
        for (int i = 0; i < N; i++) begin
            bus.commit_v_i[i]       = en[i] && (seq[i] < lim[i]);
            bus.commit_trap_i[i]    = seq[i] < trap_cnt[i];
            bus.commit_instret_i[i] = !(seq[i] < trap_cnt[i]);
            bus.commit_payload_i[i*PW +: PW] = pl(i, seq[i]);
        end
    end

    function automatic logic [PW-1:0] pl(int c, int s);
        logic [39:0] t;
        t = {c[7:0], s[31:0]};
        return PW'(t);
    endfunction

    function automatic logic [CW-1:0] cnt_of(int c);
        return bus.instr_cnt_o[c*CW +: CW];
    endfunction

    task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic consume();
        int c;
        c = int'(bus.chk_core_id_o);
        chk($sformatf("sb_payload_core%0d", c), bus.chk_payload_o, pl(c, exp_seq[c]));
        chk("sb_trap", PW'(bus.chk_trap_o), PW'(exp_seq[c] < trap_cnt[c]));
        chk("sb_instret", PW'(bus.chk_instret_o), PW'(exp_seq[c] >= trap_cnt[c]));
        exp_seq[c]++;
        n_cons++;
    endtask

    // Called at a negedge; samples handshakes for the coming posedge and returns at the next negedge.
    task automatic cyc();
        int g;
        #1;
        g = -1;
        if (rst_n) begin
            chk("ready_onehot", PW'($countones(bus.commit_ready_o) <= 1), PW'(1));
            for (int i = 0; i < N; i++)
                if (bus.commit_v_i[i] && bus.commit_ready_o[i]) g = i;
            if (bus.chk_v_o && bus.chk_yumi_i) consume();
        end
        @(posedge clk);
        @(negedge clk);
        if (g >= 0) begin
            if (seq[g] >= trap_cnt[g]) mdl_cnt[g]++;
            seq[g]++;
            n_acc++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; exp_seq[i] = 0; mdl_cnt[i] = 0;
        end
        n_acc = 0;
        n_cons = 0;
    endtask

    task automatic do_reset(bit check_held);
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        if (check_held) begin
            #1;
            chk("rst_ready", PW'(bus.commit_ready_o), PW'(0));
            chk("rst_chk_v", PW'(bus.chk_v_o), PW'(0));
            chk("rst_cnt", PW'(bus.instr_cnt_o), PW'(0));
            chk("rst_finish", PW'(bus.core_finish_o), PW'(0));
            chk("rst_done", PW'(bus.done_o), PW'(0));
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        logic [1:0]   exp_id;
    } vec_t;

    vec_t tbl[17];
    int   prev[N];
    logic [N-1:0] exp_fin;
    bit   done_seen;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd2};
        tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd3};
        tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd0};
        tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 2'd1};
        tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 2'd0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b1001, 4'b1000, 1'b0, 2'd0};
        tbl[11] = '{4'b1001, 4'b0001, 1'b1, 2'd3};
        tbl[12] = '{4'b1100, 4'b0100, 1'b1, 2'd0};
        tbl[13] = '{4'b1100, 4'b1000, 1'b1, 2'd2};
        tbl[14] = '{4'b0110, 4'b0010, 1'b1, 2'd3};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

        bus.instr_cap_i = '0;
        for (int i = 0; i < N; i++) begin
            lim[i] = BIG; trap_cnt[i] = 0;
        end

        // Reset held with every core valid, then arbitration vectors with unlimited cap.
        en = '1;
        yumi_en = 1'b1;
        @(negedge clk);
        do_reset(1'b1);
        for (int k = 0; k < 17; k++) begin
            en = tbl[k].en;
            #1;
            chk($sformatf("vec%0d_ready", k), PW'(bus.commit_ready_o), PW'(tbl[k].exp_rdy));
            chk($sformatf("vec%0d_chk_v", k), PW'(bus.chk_v_o), PW'(tbl[k].exp_v));
            if (tbl[k].exp_v) chk($sformatf("vec%0d_core_id", k), PW'(bus.chk_core_id_o), PW'(tbl[k].exp_id));
            cyc();
        end
        for (int c = 0; c < N; c++) chk($sformatf("vec_cnt%0d", c), PW'(cnt_of(c)), PW'(mdl_cnt[c]));
        chk("vec_no_finish_cap0", PW'(bus.core_finish_o), PW'(0));
        chk("vec_no_done_cap0", PW'(bus.done_o), PW'(0));
        chk("vec_no_loss", PW'(n_cons), PW'(n_acc));

        // Backpressure: output held stable while the checker stalls.
        do_reset(1'b0);
        en = '1;
        yumi_en = 1'b0;
        #1;
        chk("bp_first_ready", PW'(bus.commit_ready_o), PW'(4'b0001));
        cyc();
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp_ready_held", PW'(bus.commit_ready_o), PW'(0));
            chk("bp_payload_held", bus.chk_payload_o, pl(0, 0));
            cyc();
        end
        yumi_en = 1'b1;
        #1;
        chk("bp_resume_ready", PW'(bus.commit_ready_o), PW'(4'b0010));
        cyc();
        #1;
        chk("bp_resume_payload", bus.chk_payload_o, pl(1, 0));
        repeat (4) cyc();
        en = '0;
        repeat (3) cyc();
        chk("bp_no_loss", PW'(n_cons), PW'(n_acc));

        // Core 2 alone: three traps then four retiring records.
        do_reset(1'b0);
        lim[2] = 7;
        trap_cnt[2] = 3;
        en = 4'b0100;
        repeat (12) cyc();
        chk("trap_cnt2", PW'(cnt_of(2)), PW'(4));
        chk("trap_forwarded", PW'(exp_seq[2]), PW'(7));
        chk("trap_other_cnt", PW'(cnt_of(0) + cnt_of(1) + cnt_of(3)), PW'(0));
        lim[2] = BIG;
        trap_cnt[2] = 0;

        // Cap of 10 on every core; finish must lag the tenth retire by one cycle.
        do_reset(1'b0);
        bus.instr_cap_i = CW'(10);
        for (int i = 0; i < N; i++) lim[i] = 10;
        en = '1;
        exp_fin = '0;
        done_seen = 1'b0;
        for (int t = 0; t < 200 && !done_seen; t++) begin
            prev = mdl_cnt;
            cyc();
            #1;
            for (int c = 0; c < N; c++) if (prev[c] == 10) exp_fin[c] = 1'b1;
            chk("cap_finish", PW'(bus.core_finish_o), PW'(exp_fin));
            if (bus.done_o) begin
                done_seen = 1'b1;
                chk("done_chk_v_drained", PW'(bus.chk_v_o), PW'(0));
                chk("done_all_consumed", PW'(n_cons), PW'(40));
            end
        end
        chk("done_reached", PW'(done_seen), PW'(1));
        for (int c = 0; c < N; c++) chk($sformatf("cap_cnt%0d", c), PW'(cnt_of(c)), PW'(10));
        for (int t = 0; t < 5; t++) begin
            cyc();
            #1;
            chk("done_sticky", PW'(bus.done_o), PW'(1));
        end

        // Async reset from done, off the clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_done_clear", PW'(bus.done_o), PW'(0));
        chk("arst_finish_clear", PW'(bus.core_finish_o), PW'(0));

        // Async reset while a record sits in the output register.
        bus.instr_cap_i = '0;
        for (int i = 0; i < N; i++) lim[i] = BIG;
        do_reset(1'b0);
        yumi_en = 1'b0;
        repeat (2) cyc();
        #1;
        chk("arst_pre_chk_v", PW'(bus.chk_v_o), PW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_chk_v", PW'(bus.chk_v_o), PW'(0));
        chk("arst_ready", PW'(bus.commit_ready_o), PW'(0));
        chk("arst_cnt", PW'(bus.instr_cnt_o), PW'(0));
        yumi_en = 1'b1;
        do_reset(1'b0);
        #1;
        chk("restart_ready", PW'(bus.commit_ready_o), PW'(4'b0001));
        cyc();
        #1;
        chk("restart_chk_v", PW'(bus.chk_v_o), PW'(1));
        chk("restart_core_id", PW'(bus.chk_core_id_o), PW'(0));
        chk("restart_done", PW'(bus.done_o), PW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
